// File: rtl/xeng_acc_readout_pkg.sv
// Shared X-engine definitions: accumulator geometry derivation, stokes indices
// and the readout serialiser state type.
package xeng_acc_readout_pkg;

    localparam logic [1:0] STOKES_XX = 2'd0;
    localparam logic [1:0] STOKES_YY = 2'd1;
    localparam logic [1:0] STOKES_XY = 2'd2;
    localparam logic [1:0] STOKES_YX = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SER  = 1'b1
    } ser_state_e;

    // Width of one real or imaginary accumulator component.
    function automatic int xeng_sw(input int bitwidth, input int p_factor_bits,
                                   input int serial_acc_len_bits);
        return (2 * bitwidth + 1) + p_factor_bits + serial_acc_len_bits;
    endfunction

    function automatic int xeng_acc_width(input int sw);
        return 8 * sw;
    endfunction

    function automatic int xeng_n_bl(input int n_ants);
        return n_ants * (n_ants / 2 + 1);
    endfunction

    function automatic int xeng_bl_bits(input int n_bl);
        return (n_bl > 1) ? $clog2(n_bl) : 1;
    endfunction

endpackage

// File: rtl/xeng_readout_fifo.sv
// Synchronous ring-buffer FIFO; the head word is presented combinationally so
// the consumer registers the first word itself when it pops.
module xeng_readout_fifo
    import xeng_acc_readout_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
        if (pop_i)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[wr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_q];
    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/xeng_acc_readout.sv
// X-engine accumulator readout: tags each dump word with its baseline index,
// buffers it, and serialises it as four complex stokes beats.
module xeng_acc_readout
    import xeng_acc_readout_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 0,
    parameter int BITWIDTH            = 4,
    parameter int N_ANTS              = 8,
    parameter int FIFO_DEPTH_BITS     = 6,
    localparam int SW        = xeng_sw(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS),
    localparam int ACC_WIDTH = xeng_acc_width(SW),
    localparam int N_BL      = xeng_n_bl(N_ANTS),
    localparam int BL_BITS   = xeng_bl_bits(N_BL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_in,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 valid_in,
    output logic [2*SW-1:0]      dout,
    output logic [1:0]           dout_stokes,
    output logic [BL_BITS-1:0]   dout_bl,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overflow,
    output ser_state_e           dbg_state_o
);

    localparam int DW = 2 * SW;
    localparam int FW = ACC_WIDTH + BL_BITS;
    // The holding register acts as the last buffer slot, so the whole path
    // holds exactly 2^FIFO_DEPTH_BITS words.
    localparam int FIFO_SLOTS = (1 << FIFO_DEPTH_BITS) - 1;
    localparam logic [BL_BITS-1:0] BL_LAST = BL_BITS'(N_BL - 1);

    ser_state_e           state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [ACC_WIDTH-1:0] hold_q, hold_d;
    logic [BL_BITS-1:0]   hold_bl_q, hold_bl_d;
    logic [BL_BITS-1:0]   bl_cnt_q, bl_cnt_d, tag;
    logic                 overflow_q, overflow_d;

    logic                 push, pop, xfer;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_rdata;
    logic [DW-1:0]        beat_words [4];

    function automatic logic [BL_BITS-1:0] bl_inc(input logic [BL_BITS-1:0] b);
        return (b == BL_LAST) ? '0 : b + 1'b1;
    endfunction

    // Input side: the counter advances on every valid_in, even a dropped one.
    always_comb begin
        tag        = sync_in ? '0 : bl_cnt_q;
        bl_cnt_d   = bl_cnt_q;
        if (valid_in)     bl_cnt_d = bl_inc(tag);
        else if (sync_in) bl_cnt_d = '0;
        push       = valid_in && (!fifo_full || pop);
        overflow_d = overflow_q || (valid_in && fifo_full && !pop);
    end

    // Handshake: a beat transfers on a cycle where dout_valid && dout_ready;
    // while valid is high without ready, every output holds its value.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        hold_bl_d = hold_bl_q;
        pop       = 1'b0;
        xfer      = (state_q == ST_SER) && dout_ready;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SER;
                    beat_d  = STOKES_XX;
                end
            end
            ST_SER: begin
                if (xfer) begin
                    if (beat_q == STOKES_YX) begin
                        beat_d = STOKES_XX;
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            hold_d    = fifo_rdata[ACC_WIDTH-1:0];
            hold_bl_d = fifo_rdata[FW-1:ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            hold_q     <= '0;
            hold_bl_q  <= '0;
            bl_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            hold_q     <= hold_d;
            hold_bl_q  <= hold_bl_d;
            bl_cnt_q   <= bl_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    xeng_readout_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_SLOTS)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i({tag, acc_in}),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        for (int k = 0; k < 4; k++) beat_words[k] = hold_q[k*DW +: DW];
    end

    assign dout        = beat_words[beat_q];
    assign dout_stokes = beat_q;
    assign dout_bl     = hold_bl_q;
    assign dout_valid  = (state_q == ST_SER);
    assign dout_last   = dout_valid && (beat_q == STOKES_YX) && (hold_bl_q == BL_LAST);
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xeng_acc_readout.sv
// Bench for xeng_acc_readout at default parameters (40 baselines, 32-bit beats,
// 64-word buffering).
module tb_xeng_acc_readout;
  import xeng_acc_readout_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 128;
  localparam int N_BL = 40;
  localparam int BLB  = 6;
  localparam int CAP  = 64;
  localparam int EW   = 1 + BLB + 2 + DW;

  logic           clk = 1'b0;
  logic           rst, sync_in, valid_in;
  logic           dout_ready = 1'b0;
  logic [AW-1:0]  acc_in;
  logic [DW-1:0]  dout;
  logic [1:0]     dout_stokes;
  logic [BLB-1:0] dout_bl;
  logic           dout_last, dout_valid, overflow;
  ser_state_e     dbg_state;

  xeng_acc_readout dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
    .dout(dout), .dout_stokes(dout_stokes), .dout_bl(dout_bl), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int unsigned   xfer_cyc_q[$];
  int            n_cmp = 0, n_bad = 0;
  int            tag_cnt = 0, occ = 0;
  int            n_beats = 0, n_last = 0;
  int            ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = (cyc % 3 == 0);
      2: dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // monitor: pops one expected beat per transfer, checks stalls hold steady
  logic          stall_prev = 1'b0;
  logic [EW-1:0] prev_out;
  always @(negedge clk) begin
    logic [EW-1:0] act, e;
    act = {dout_last, dout_bl, dout_stokes, dout};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(dout_valid), 64'd1);
        check("stall_hold", 64'(act), 64'(prev_out));
      end
      if (dout_valid && dout_ready) begin
        n_beats++;
        if (dout_last) n_last++;
        xfer_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(act), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(act), 64'(e));
          if (e[DW+1:DW] == 2'd3) occ--;
        end
      end
      stall_prev = dout_valid && !dout_ready;
      prev_out   = act;
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic send_word(input logic [AW-1:0] w, input bit s);
    int tag;
    acc_in   = w;
    valid_in = 1'b1;
    sync_in  = s;
    tag      = s ? 0 : tag_cnt;
    tag_cnt  = (tag + 1) % N_BL;
    if (occ < CAP) begin
      occ++;
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(tag == N_BL - 1 && k == 3), BLB'(tag), 2'(k), w[k*DW +: DW]});
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic do_sync();
    sync_in = 1'b1;
    tag_cnt = 0;
    @(posedge clk); #1;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, b0, l0;
    logic [AW-1:0] w;
    rst = 1'b1; sync_in = 1'b0; valid_in = 1'b0; acc_in = '0;
    ready_mode = 0;
    idle(1);
    valid_in = 1'b1;
    acc_in = rand_word();
    idle(2);
    valid_in = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_outs", 64'({dout_last, dout_bl, dout_stokes, dout}), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(dout_valid), 64'd0);
    check("post_rst_outs", 64'({dout_last, dout_bl, dout_stokes, dout}), 64'd0);
    idle(2);

    // single word, reals 1..4, latency and back-to-back beats
    xfer_cyc_q.delete();
    w = '0;
    for (int k = 0; k < 4; k++) w[k*DW +: DW] = {16'($urandom), 16'(k + 1)};
    t0 = cyc;
    send_word(w, 1'b0);
    wait_drain(50);
    check("lat_nbeats", 64'(xfer_cyc_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < xfer_cyc_q.size(); i++)
      check("lat_cycle", 64'(xfer_cyc_q[i]), 64'(t0 + 2 + i));

    // full dump of 40 spaced words after sync
    b0 = n_beats; l0 = n_last;
    do_sync();
    for (int i = 0; i < N_BL; i++) begin
      send_word(rand_word(), 1'b0);
      idle($urandom_range(3, 6));
    end
    wait_drain(200);
    check("dump_beats", 64'(n_beats - b0), 64'd160);
    check("dump_last", 64'(n_last - l0), 64'd1);

    // ready 1-of-3
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      send_word(rand_word(), 1'b0);
      idle($urandom_range(0, 3));
    end
    wait_drain(400);

    // sync mid-stream with a word in the same cycle
    ready_mode = 2;
    do_sync();
    for (int i = 0; i < 17; i++) begin
      send_word(rand_word(), 1'b0);
      idle($urandom_range(0, 2));
    end
    send_word(rand_word(), 1'b1);
    send_word(rand_word(), 1'b0);
    wait_drain(600);

    // random traffic with occasional syncs
    for (int i = 0; i < 40; i++) begin
      send_word(rand_word(), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 5));
    end
    wait_drain(800);
    check("no_overflow", 64'(overflow), 64'd0);

    // overflow: 65 words into a stalled output
    ready_mode = 3;
    idle(2);
    do_sync();
    for (int i = 1; i <= 65; i++) begin
      send_word(rand_word(), 1'b0);
      if (i == 64) check("ovf_before", 64'(overflow), 64'd0);
    end
    check("ovf_after", 64'(overflow), 64'd1);
    ready_mode = 0;
    wait_drain(400);
    send_word(rand_word(), 1'b0);
    wait_drain(50);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // reset on beat 2 of a word with 3 more queued
    for (int i = 0; i < 4; i++) send_word(rand_word(), 1'b0);
    rst = 1'b1;
    valid_in = 1'b1;
    acc_in = rand_word();
    exp_q.delete();
    occ = 0;
    tag_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 64'(dout_valid), 64'd0);
    check("rst_mid_overflow", 64'(overflow), 64'd0);
    idle(3);
    check("rst_mid_quiet", 64'(dout_valid), 64'd0);
    send_word(rand_word(), 1'b0);
    wait_drain(50);
    check("final_overflow", 64'(overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
